// File: rtl/alu_arbiter_if.sv
// Signal bundle between alu_arbiter (slave) and its requesters plus the shared ALU (master).
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [4:0]  req0_shamt;
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [4:0]  req1_shamt;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_overflow;
  logic        rsp_less;
  logic        rsp_err;
  logic [31:0] alu_operand_A;
  logic [31:0] alu_operand_B;
  logic [3:0]  alu_control;
  logic [4:0]  alu_shmant;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_shamt,
    input  req1_valid, req1_op, req1_a, req1_b, req1_shamt,
    input  rsp0_ready, rsp1_ready, alu_result, alu_overflow,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_zero, rsp_overflow, rsp_less, rsp_err,
    output alu_operand_A, alu_operand_B, alu_control, alu_shmant, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_shamt,
    output req1_valid, req1_op, req1_a, req1_b, req1_shamt,
    output rsp0_ready, rsp1_ready, alu_result, alu_overflow,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_zero, rsp_overflow, rsp_less, rsp_err,
    input  alu_operand_A, alu_operand_B, alu_control, alu_shmant, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter/sequencer for the shared registered ALU; response 3 cycles after accept (illegal op: 1).
// Readies are high only in IDLE for the winner; a response holds stable until its rspN_ready.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [4:0]  shamt_q;
  logic        owner_q, last_q;
  logic [31:0] result_q;
  logic        zero_q, ovf_q, less_q, err_q;
  logic        grant0, grant1, accept, drive_alu;
  logic [3:0]  sel_op;

  function automatic logic is_legal(input logic [3:0] op);
    return (op >= 4'b0010) && (op <= 4'b1100);
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    return (op == 4'b0010) || (op == 4'b0011) || (op == 4'b1011) || (op == 4'b1100);
  endfunction

  // last_q == 1 means port 1 was served last, so port 0 takes the tie.
  assign grant0 = bus.req0_valid && (!bus.req1_valid || FIXED_PRIO || last_q);
  assign grant1 = bus.req1_valid && !grant0;
  assign sel_op = grant1 ? bus.req1_op : bus.req0_op;

  always_comb begin
    state_nxt      = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.busy       = (state != IDLE);
    accept         = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_ready = grant0 && !reset;
        bus.req1_ready = grant1 && !reset;
        accept         = (grant0 || grant1) && !reset;
        if (accept)
          state_nxt = is_legal(sel_op) ? ISSUE : RESP;
      end
      ISSUE: state_nxt = WAIT;
      WAIT:  state_nxt = RESP;
      RESP: begin
        bus.rsp0_valid = !owner_q;
        bus.rsp1_valid = owner_q;
        if (owner_q ? bus.rsp1_ready : bus.rsp0_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Illegal ops never reach the ALU, so its inputs stay at 0 for them.
  assign drive_alu         = (state != IDLE) && is_legal(op_q);
  assign bus.alu_control   = drive_alu ? op_q    : 4'd0;
  assign bus.alu_operand_A = drive_alu ? a_q     : 32'd0;
  assign bus.alu_operand_B = drive_alu ? b_q     : 32'd0;
  assign bus.alu_shmant    = drive_alu ? shamt_q : 5'd0;

  assign bus.rsp_result   = result_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_overflow = ovf_q;
  assign bus.rsp_less     = less_q;
  assign bus.rsp_err      = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= 4'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      shamt_q  <= 5'd0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      less_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= sel_op;
        a_q     <= grant1 ? bus.req1_a     : bus.req0_a;
        b_q     <= grant1 ? bus.req1_b     : bus.req0_b;
        shamt_q <= grant1 ? bus.req1_shamt : bus.req0_shamt;
        owner_q <= grant1;
        last_q  <= grant1;
        if (!is_legal(sel_op)) begin
          result_q <= 32'd0;
          zero_q   <= 1'b0;
          ovf_q    <= 1'b0;
          less_q   <= 1'b0;
          err_q    <= 1'b1;
        end
      end
      if (state == WAIT) begin
        result_q <= bus.alu_result;
        zero_q   <= (bus.alu_result == 32'd0);
        less_q   <= bus.alu_result[31];
        ovf_q    <= is_arith(op_q) ? bus.alu_overflow : 1'b0;
        err_q    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: a round-robin and a fixed-priority alu_arbiter, each with a registered ALU model
// whose overflow flag only updates on arithmetic ops.
module tb_alu_arbiter;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter_if b0 ();
  alu_arbiter_if b1 ();

  alu_arbiter #(.FIXED_PRIO(1'b0)) u_rr (.clk(clk), .reset(reset), .bus(b0));
  alu_arbiter #(.FIXED_PRIO(1'b1)) u_fp (.clk(clk), .reset(reset), .bus(b1));

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'b0010, 4'b1100: return a + b;
      4'b0011, 4'b1011: return a - b;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b0110: return a ^ b;
      4'b0111: return ~a;
      4'b1000: return a << sh;
      4'b1001: return a >> sh;
      4'b1010: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ovf_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s, d;
    s = a + b;
    d = a - b;
    case (op)
      4'b0010: return (a[31] == b[31]) && (s[31] != a[31]);
      4'b0011: return (a[31] != b[31]) && (d[31] != a[31]);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic upd_ovf(input logic [3:0] op);
    return (op == 4'b0010) || (op == 4'b0011) || (op == 4'b1011) || (op == 4'b1100);
  endfunction

  always @(posedge clk) begin
    b0.alu_result <= alu_f(b0.alu_control, b0.alu_operand_A, b0.alu_operand_B, b0.alu_shmant);
    if (reset) b0.alu_overflow <= 1'b0;
    else if (upd_ovf(b0.alu_control))
      b0.alu_overflow <= ovf_f(b0.alu_control, b0.alu_operand_A, b0.alu_operand_B);
  end

  always @(posedge clk) begin
    b1.alu_result <= alu_f(b1.alu_control, b1.alu_operand_A, b1.alu_operand_B, b1.alu_shmant);
    if (reset) b1.alu_overflow <= 1'b0;
    else if (upd_ovf(b1.alu_control))
      b1.alu_overflow <= ovf_f(b1.alu_control, b1.alu_operand_A, b1.alu_operand_B);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    b0.req0_valid = 1'b1; b0.req0_op = op; b0.req0_a = a; b0.req0_b = b; b0.req0_shamt = sh;
  endtask

  task automatic req1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    b0.req1_valid = 1'b1; b0.req1_op = op; b0.req1_a = a; b0.req1_b = b; b0.req1_shamt = sh;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    b0.req0_valid = 0; b0.req0_op = 0; b0.req0_a = 0; b0.req0_b = 0; b0.req0_shamt = 0;
    b0.req1_valid = 0; b0.req1_op = 0; b0.req1_a = 0; b0.req1_b = 0; b0.req1_shamt = 0;
    b0.rsp0_ready = 0; b0.rsp1_ready = 0;
    b1.req0_valid = 0; b1.req0_op = 0; b1.req0_a = 0; b1.req0_b = 0; b1.req0_shamt = 0;
    b1.req1_valid = 0; b1.req1_op = 0; b1.req1_a = 0; b1.req1_b = 0; b1.req1_shamt = 0;
    b1.rsp0_ready = 0; b1.rsp1_ready = 0;
    #1;
    chk("rst_busy",  b0.busy, 1'b0);
    chk("rst_rsp0",  b0.rsp0_valid, 1'b0);
    chk("rst_rsp1",  b0.rsp1_valid, 1'b0);
    chk("rst_res",   b0.rsp_result, 32'd0);
    chk("rst_ctrl",  b0.alu_control, 4'd0);
    chk("rst_opa",   b0.alu_operand_A, 32'd0);
    chk("rst_fbusy", b1.busy, 1'b0);
    cyc(); cyc();
    reset = 1'b0;

    // Single ADD on port 0
    req0(4'b0010, 32'd5, 32'd7, 5'd0);
    b0.rsp0_ready = 1'b1;
    #1 chk("t1_rdy0", b0.req0_ready, 1'b1);
    cyc();
    b0.req0_valid = 1'b0;
    chk("t1_busy", b0.busy, 1'b1);
    chk("t1_ctrl", b0.alu_control, 4'b0010);
    chk("t1_opa",  b0.alu_operand_A, 32'd5);
    chk("t1_opb",  b0.alu_operand_B, 32'd7);
    chk("t1_rsp0_early", b0.rsp0_valid, 1'b0);
    cyc();
    chk("t1_rsp0_wait", b0.rsp0_valid, 1'b0);
    cyc();
    chk("t1_rsp0", b0.rsp0_valid, 1'b1);
    chk("t1_res",  b0.rsp_result, 32'd12);
    chk("t1_zero", b0.rsp_zero, 1'b0);
    chk("t1_less", b0.rsp_less, 1'b0);
    chk("t1_ovf",  b0.rsp_overflow, 1'b0);
    chk("t1_err",  b0.rsp_err, 1'b0);
    chk("t1_rsp1", b0.rsp1_valid, 1'b0);
    cyc();
    chk("t1_idle", b0.busy, 1'b0);
    chk("t1_rsp0_off", b0.rsp0_valid, 1'b0);
    chk("t1_ctrl0", b0.alu_control, 4'd0);

    // Round-robin ties after a fresh reset
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    req0(4'b0011, 32'd3, 32'd3, 5'd0);
    req1(4'b0110, 32'h0000F0F0, 32'h00000F0F, 5'd0);
    b0.rsp0_ready = 1'b1;
    b0.rsp1_ready = 1'b1;
    #1;
    chk("t2_tie1_rdy0", b0.req0_ready, 1'b1);
    chk("t2_tie1_rdy1", b0.req1_ready, 1'b0);
    cyc();
    req0(4'b0010, 32'd1, 32'd1, 5'd0);
    #1 chk("t2_busy_rdy1", b0.req1_ready, 1'b0);
    cyc(); cyc();
    chk("t2_rsp0", b0.rsp0_valid, 1'b1);
    chk("t2_rsp1_lo", b0.rsp1_valid, 1'b0);
    chk("t2_res0", b0.rsp_result, 32'd0);
    chk("t2_zero0", b0.rsp_zero, 1'b1);
    cyc();
    chk("t2_tie2_rdy1", b0.req1_ready, 1'b1);
    chk("t2_tie2_rdy0", b0.req0_ready, 1'b0);
    cyc();
    b0.req1_valid = 1'b0;
    cyc(); cyc();
    chk("t2_rsp1", b0.rsp1_valid, 1'b1);
    chk("t2_rsp0_lo", b0.rsp0_valid, 1'b0);
    chk("t2_res1", b0.rsp_result, 32'h0000FFFF);
    chk("t2_zero1", b0.rsp_zero, 1'b0);
    cyc();
    chk("t2_rdy0_again", b0.req0_ready, 1'b1);
    cyc();
    b0.req0_valid = 1'b0;
    cyc(); cyc();
    chk("t2_rsp0_b", b0.rsp0_valid, 1'b1);
    chk("t2_res0_b", b0.rsp_result, 32'd2);
    cyc();

    // Backpressure on port 0 with a waiting port-1 request
    b0.rsp0_ready = 1'b0;
    req0(4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0);
    cyc();
    b0.req0_valid = 1'b0;
    req1(4'b0101, 32'h10, 32'h01, 5'd0);
    cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_vld",  b0.rsp0_valid, 1'b1);
      chk("t3_hold_res",  b0.rsp_result, 32'h80000000);
      chk("t3_hold_less", b0.rsp_less, 1'b1);
      chk("t3_hold_ovf",  b0.rsp_overflow, 1'b1);
      chk("t3_hold_rdy1", b0.req1_ready, 1'b0);
      cyc();
    end
    b0.rsp0_ready = 1'b1;
    chk("t3_still_vld", b0.rsp0_valid, 1'b1);
    cyc();
    chk("t3_idle", b0.busy, 1'b0);
    chk("t3_rsp0_off", b0.rsp0_valid, 1'b0);
    chk("t3_rdy1", b0.req1_ready, 1'b1);
    cyc();
    b0.req1_valid = 1'b0;
    cyc(); cyc();
    chk("t3_rsp1", b0.rsp1_valid, 1'b1);
    chk("t3_res1", b0.rsp_result, 32'h00000011);
    chk("t3_ovf_logic", b0.rsp_overflow, 1'b0);
    chk("t3_less1", b0.rsp_less, 1'b0);
    cyc();

    // Illegal opcode on port 1
    req1(4'b1111, 32'd123, 32'd1, 5'd0);
    #1;
    chk("t4_rdy1", b0.req1_ready, 1'b1);
    chk("t4_ctrl_idle", b0.alu_control, 4'd0);
    cyc();
    b0.req1_valid = 1'b0;
    chk("t4_rsp1", b0.rsp1_valid, 1'b1);
    chk("t4_res", b0.rsp_result, 32'd0);
    chk("t4_err", b0.rsp_err, 1'b1);
    chk("t4_zero", b0.rsp_zero, 1'b0);
    chk("t4_ovf", b0.rsp_overflow, 1'b0);
    chk("t4_ctrl", b0.alu_control, 4'd0);
    chk("t4_rsp0", b0.rsp0_valid, 1'b0);
    cyc();
    chk("t4_rsp1_off", b0.rsp1_valid, 1'b0);
    chk("t4_ctrl_after", b0.alu_control, 4'd0);

    // Reset during WAIT of an SLL
    req0(4'b1000, 32'd1, 32'd0, 5'd4);
    cyc();
    b0.req0_valid = 1'b0;
    chk("t5_ctrl", b0.alu_control, 4'b1000);
    chk("t5_sh", b0.alu_shmant, 5'd4);
    cyc();
    reset = 1'b1;
    #1;
    chk("t5_busy", b0.busy, 1'b0);
    chk("t5_rsp0", b0.rsp0_valid, 1'b0);
    chk("t5_ctrl0", b0.alu_control, 4'd0);
    chk("t5_opa0", b0.alu_operand_A, 32'd0);
    chk("t5_sh0", b0.alu_shmant, 5'd0);
    chk("t5_err0", b0.rsp_err, 1'b0);
    chk("t5_res0", b0.rsp_result, 32'd0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_rsp", b0.rsp0_valid, 1'b0);
      cyc();
    end
    req0(4'b1000, 32'd1, 32'd0, 5'd4);
    cyc();
    b0.req0_valid = 1'b0;
    cyc(); cyc();
    chk("t5_rsp0_b", b0.rsp0_valid, 1'b1);
    chk("t5_res16", b0.rsp_result, 32'd16);
    cyc();

    // Fixed priority: both ports valid for three operations
    b1.rsp0_ready = 1'b1;
    b1.rsp1_ready = 1'b1;
    b1.req0_valid = 1'b1; b1.req0_op = 4'b0010; b1.req0_b = 32'd100;
    b1.req1_valid = 1'b1; b1.req1_op = 4'b0100; b1.req1_a = 32'hFF; b1.req1_b = 32'h0F;
    for (int i = 0; i < 3; i++) begin
      b1.req0_a = 32'(i + 1);
      #1;
      chk("t6_rdy0", b1.req0_ready, 1'b1);
      chk("t6_rdy1", b1.req1_ready, 1'b0);
      cyc(); cyc(); cyc();
      chk("t6_rsp0", b1.rsp0_valid, 1'b1);
      chk("t6_rsp1", b1.rsp1_valid, 1'b0);
      chk("t6_res", b1.rsp_result, 32'(101 + i));
      cyc();
    end
    b1.req0_valid = 1'b0;
    b1.req1_valid = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared registered ALU in the single-cycle CPU. It accepts operation requests from two requesters (port 0: main execute path, port 1: branch/compare unit) over valid/ready handshakes and grants one at a time. It drives the ALU operand and control inputs, waits out the ALU's one-cycle registered latency, and returns result plus flags to the granted requester over a valid/ready response handshake.

## Interface
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = port 0 always wins ties
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- reqN_valid  in  1  request N present (N = 0, 1)
- reqN_ready  out  1  request N accepted this cycle
- reqN_op  in  4  ALU opcode
- reqN_a, reqN_b  in  32  operands A, B
- reqN_shamt  in  5  shift amount
- rspN_valid  out  1  response N available
- rspN_ready  in  1  requester N takes response
- rsp_result  out  32  captured result, shared by both ports
- rsp_zero, rsp_overflow, rsp_less, rsp_err  out  1  captured flags, shared by both ports
- alu_operand_A, alu_operand_B  out  32  to ALU
- alu_control  out  4  to ALU
- alu_shmant  out  5  to ALU
- alu_result  in  32  from ALU (registered)
- alu_overflow  in  1  from ALU
- busy  out  1  FSM not in IDLE

## Operation
- Legal opcodes: 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOT, 1000 SLL, 1001 SRL, 1010 NOR, 1011 SUBU, 1100 ADDU. Any other opcode is illegal.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: arbitrate. reqN_ready is high only for the winner, and only in IDLE. Both readies are low in every other state.
  - On an accept edge (valid & ready), latch op, a, b, shamt and owner, then move to ISSUE.
  - Illegal opcode: go from IDLE directly to RESP with result 0, rsp_err = 1, all other flags 0. The ALU is not issued.
  - ISSUE: alu_* outputs are driven from the latched request; the ALU registers at the end of this cycle. Next state is WAIT.
  - WAIT: alu_result is valid. At the end of the cycle, capture:
    - rsp_result = alu_result
    - rsp_zero = (alu_result == 0)
    - rsp_less = alu_result[31]
    - rsp_overflow = alu_overflow for ADD/SUB/SUBU/ADDU, forced to 0 for all other ops (the ALU does not update overflow on logic ops)
    - rsp_err = 0
    - Next state is RESP.
  - RESP: rspN_valid is high for the owner only. It holds, with all rsp_* stable, until rspN_ready. On that handshake edge, return to IDLE.
- Arbitration:
  - Only one requester valid: that requester wins.
  - Both valid, FIXED_PRIO = 0: the port not served last wins. The last-served register resets to 1, so port 0 wins the first tie.
  - Both valid, FIXED_PRIO = 1: port 0 wins.
- While not IDLE, alu_* outputs hold the latched request. In IDLE they are 0, alu_control included (the ALU default yields 0).
- A request left unserved keeps its valid asserted. The arbiter never drops a valid request.

## Timing
- Reset values: state IDLE, every output 0 (reqN_ready, rspN_valid, rsp_*, alu_*, busy), last-served = 1.
- Legal op: accept edge T0 → ISSUE in cycle T0+1 → WAIT in T0+2 → rspN_valid high in T0+3. Minimum 3 cycles from accept to valid.
- Illegal op: rspN_valid high in the cycle after accept.
- Back-to-back throughput: with rsp_ready held high, one op per 4 cycles. The RESP handshake cycle is followed by an IDLE cycle, and a new accept can occur in that IDLE cycle.
- reqN_ready is combinational from reqN_valid and state. No combinational path exists from rspN_ready to any output.
- Reset asserted mid-operation (any state): immediately return to IDLE with all outputs 0. The in-flight op is dropped with no response. The late ALU result is ignored.
- A request arriving while busy: it waits, with its ready low, until IDLE.

## Test plan
- Reset, then req0 ADD a = 5, b = 7 with rsp0_ready = 1 → rsp0_valid in the 3rd cycle after accept; result 12, zero 0, less 0, overflow 0, err 0; rsp1_valid stays 0.
- req0 and req1 valid together with SUB 3−3 and XOR 0xF0F0^0x0F0F, FIXED_PRIO = 0 → port 0 is served first (result 0, zero 1). Port 1 is then served (result 0x0000FFFF). A second tie is won by port 1.
- rsp0_ready held low for 5 cycles on ADD 0x7FFFFFFF+1 → rsp0_valid and result 0x80000000, less 1 stay stable all 5 cycles; no new accept occurs; IDLE follows the handshake.
- req1 op 1111 → rsp1_valid in the next cycle, result 0, err 1; alu_control remains 0 throughout.
- Reset pulsed during WAIT of SLL a = 1, shamt = 4 → all outputs 0 immediately; no response. A subsequent SLL returns 16.
- FIXED_PRIO = 1, both valid continuously for 3 ops → port 0 is granted all 3 times.
